// File: rtl/alu_pkg.sv
// alu_pkg: operation encodings, flag bit positions and a flag-packing helper
// shared by the ALU and its decimal-adjust sub-block.
package alu_pkg;

  // Operation select encodings; every other mode value is a pass-through.
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_AND = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_EOR = 5'd3;
  localparam logic [4:0] ALU_SR  = 5'd4;
  localparam logic [4:0] ALU_SUB = 5'd5;

  // Bit positions inside flags_q.
  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Assemble the {N,V,Z,C} flag nibble from individual flag bits.
  function automatic logic [3:0] pack_flags(input logic n, input logic v,
                                            input logic z, input logic c);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_bcd_adjust.sv
// alu_bcd_adjust: NMOS-6502 style decimal correction of a binary ADC/SBC
// result. Present only when ALU_DECIMAL_EN is defined.
`ifdef ALU_DECIMAL_EN
module alu_bcd_adjust
  import alu_pkg::*;
(
  input  logic [7:0] bin_res,
  input  logic       half_carry,
  input  logic       carry,
  input  logic       op_sub,
  output logic [7:0] adj_res,
  output logic       adj_carry
);

  logic [8:0] lo_fix_s;
  logic [3:0] lo_nib_s;
  logic [3:0] hi_nib_s;

  // Correct each nibble: +6 on decimal overflow for add, -6 on borrow for sub.
  always_comb begin
    lo_fix_s  = {1'b0, bin_res};
    lo_nib_s  = bin_res[3:0];
    hi_nib_s  = bin_res[7:4];
    adj_res   = bin_res;
    adj_carry = carry;
    if (op_sub) begin
      // A clear carry out of a nibble means that nibble borrowed.
      if (!half_carry) begin
        lo_nib_s = bin_res[3:0] - 4'd6;
      end else begin
        lo_nib_s = bin_res[3:0];
      end
      if (!carry) begin
        hi_nib_s = bin_res[7:4] - 4'd6;
      end else begin
        hi_nib_s = bin_res[7:4];
      end
      adj_res   = {hi_nib_s, lo_nib_s};
      adj_carry = carry;
    end else begin
      // Low-nibble fix may ripple into the high nibble before it is checked.
      if (half_carry || (bin_res[3:0] > 4'd9)) begin
        lo_fix_s = {1'b0, bin_res} + 9'd6;
      end else begin
        lo_fix_s = {1'b0, bin_res};
      end
      if (carry || lo_fix_s[8] || (lo_fix_s[7:0] > 8'h9F)) begin
        adj_res   = lo_fix_s[7:0] + 8'h60;
        adj_carry = 1'b1;
      end else begin
        adj_res   = lo_fix_s[7:0];
        adj_carry = 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/alu.sv
// alu: 8-bit 6502-compatible arithmetic/logic unit with combinational result
// and flags plus a registered {N,V,Z,C} copy.
// Optional feature: define ALU_DECIMAL_EN to enable BCD correction of
// ADD/SUB when the decimal input is high.
module alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [4:0] mode,
  input  logic       carry_in,
  input  logic       decimal,
  input  logic       flag_we,
  output logic [7:0] alu_out,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero,
  output logic       sign,
  output logic [3:0] flags_q
);

  logic [7:0] b_eff_s;
  logic [8:0] sum_s;
  logic [7:0] bin_out_s;
  logic       bin_carry_s;
  logic       ovf_s;

  // SBC is ADC with the inverted operand; one 9-bit adder serves both.
  always_comb begin
    if (mode == ALU_SUB) begin
      b_eff_s = ~alu_b;
    end else begin
      b_eff_s = alu_b;
    end
    sum_s = {1'b0, alu_a} + {1'b0, b_eff_s} + {8'h00, carry_in};
  end

  // Binary result, carry and overflow for the selected operation.
  always_comb begin
    bin_out_s   = alu_a;
    bin_carry_s = carry_in;
    ovf_s       = 1'b0;
    case (mode)
      ALU_ADD, ALU_SUB: begin
        bin_out_s   = sum_s[7:0];
        bin_carry_s = sum_s[8];
        ovf_s       = (alu_a[7] == b_eff_s[7]) && (sum_s[7] != alu_a[7]);
      end
      ALU_AND: begin
        bin_out_s = alu_a & alu_b;
      end
      ALU_OR: begin
        bin_out_s = alu_a | alu_b;
      end
      ALU_EOR: begin
        bin_out_s = alu_a ^ alu_b;
      end
      ALU_SR: begin
        bin_out_s   = {carry_in, alu_a[7:1]};
        bin_carry_s = alu_a[0];
      end
      default: begin
        bin_out_s   = alu_a;
        bin_carry_s = carry_in;
      end
    endcase
  end

`ifdef ALU_DECIMAL_EN
  logic [4:0] lo_sum_s;
  logic [7:0] dec_out_s;
  logic       dec_carry_s;
  logic       arith_s;

  // Carry out of the low nibble, needed for the decimal correction.
  always_comb begin
    lo_sum_s = {1'b0, alu_a[3:0]} + {1'b0, b_eff_s[3:0]} + {4'h0, carry_in};
    arith_s  = (mode == ALU_ADD) || (mode == ALU_SUB);
  end

  alu_bcd_adjust u_bcd (
    .bin_res    (sum_s[7:0]),
    .half_carry (lo_sum_s[4]),
    .carry      (sum_s[8]),
    .op_sub     (mode == ALU_SUB),
    .adj_res    (dec_out_s),
    .adj_carry  (dec_carry_s)
  );

  // Substitute the BCD-corrected byte and carry for decimal ADD/SUB.
  always_comb begin
    if (decimal && arith_s) begin
      alu_out   = dec_out_s;
      carry_out = dec_carry_s;
    end else begin
      alu_out   = bin_out_s;
      carry_out = bin_carry_s;
    end
  end
`else
  logic unused_s;
  assign unused_s = decimal;

  // Binary-only build: result and carry come straight from the binary path.
  always_comb begin
    alu_out   = bin_out_s;
    carry_out = bin_carry_s;
  end
`endif

  // N, Z and V always reflect the binary result (identical to alu_out
  // except for decimal-corrected arithmetic).
  always_comb begin
    overflow = ovf_s;
    zero     = (bin_out_s == 8'h00);
    sign     = bin_out_s[7];
  end

  // Flag register: reset wins over capture; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= pack_flags(sign, overflow, zero, carry_out);
    end else begin
      flags_q <= flags_q;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized scoreboard bench for alu. The driver pushes expected
// responses computed with plain integer arithmetic; a negedge monitor pops
// and compares each one against the DUT.
module tb_alu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] alu_a = 8'h00;
  logic [7:0] alu_b = 8'h00;
  logic [4:0] mode = 5'd0;
  logic       carry_in = 1'b0;
  logic       decimal = 1'b0;
  logic       flag_we = 1'b0;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       overflow;
  logic       zero;
  logic       sign;
  logic [3:0] flags_q;

  int total = 0;
  int bad = 0;

  typedef struct {
    int       out;
    int       c;
    int       v;
    int       z;
    int       n;
    int       rst;
    int       we;
    string    tag;
  } exp_t;

  exp_t sbq[$];

  alu dut (
    .clk       (clk),
    .reset     (reset),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .mode      (mode),
    .carry_in  (carry_in),
    .decimal   (decimal),
    .flag_we   (flag_we),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .sign      (sign),
    .flags_q   (flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference model from the arithmetic definition of each operation.
  task automatic model(input int m, input int a, input int b, input int cin,
                       input int dec, output exp_t e);
    int r;
    int sr;
    int lo;
    int hi;
    int borrow;
    e.v = 0;
    e.c = cin;
    e.out = a;
    if (m == 0) begin
      r = a + b + cin;
      e.out = r % 256;
      e.c = (r > 255) ? 1 : 0;
      sr = to_signed(a) + to_signed(b) + cin;
      e.v = (sr > 127 || sr < -128) ? 1 : 0;
    end else if (m == 5) begin
      r = a + (255 - b) + cin;
      e.out = r % 256;
      e.c = (r > 255) ? 1 : 0;
      sr = to_signed(a) - to_signed(b) - (1 - cin);
      e.v = (sr > 127 || sr < -128) ? 1 : 0;
    end else if (m == 1) begin
      e.out = a & b;
    end else if (m == 2) begin
      e.out = a | b;
    end else if (m == 3) begin
      e.out = a ^ b;
    end else if (m == 4) begin
      e.out = cin * 128 + a / 2;
      e.c = a % 2;
    end
    e.z = (e.out == 0) ? 1 : 0;
    e.n = (e.out >= 128) ? 1 : 0;
`ifdef ALU_DECIMAL_EN
    if (dec != 0 && m == 0) begin
      lo = a % 16 + b % 16 + cin;
      if (lo > 9) lo = lo + 6;
      hi = a / 16 + b / 16 + ((lo > 15) ? 1 : 0);
      if (hi > 9) hi = hi + 6;
      e.out = (hi % 16) * 16 + lo % 16;
      e.c = (hi > 15) ? 1 : 0;
    end else if (dec != 0 && m == 5) begin
      lo = a % 16 - b % 16 - (1 - cin);
      borrow = (lo < 0) ? 1 : 0;
      if (lo < 0) lo = lo - 6;
      hi = a / 16 - b / 16 - borrow;
      if (hi < 0) hi = hi - 6;
      e.out = ((hi + 32) % 16) * 16 + (lo + 32) % 16;
    end
`else
    lo = dec;
    hi = lo;
    borrow = hi;
`endif
  endtask

  task automatic drive(input string tag, input int m, input int a, input int b,
                       input int cin, input int dec, input int we, input int rst);
    exp_t e;
    @(posedge clk);
    #1;
    mode     = m[4:0];
    alu_a    = a[7:0];
    alu_b    = b[7:0];
    carry_in = cin[0];
    decimal  = dec[0];
    flag_we  = we[0];
    reset    = rst[0];
    model(m, a, b, cin, dec, e);
    e.rst = rst;
    e.we  = we;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  // Monitor: compare combinational outputs and the flag register model.
  int   flags_known = 0;
  logic [3:0] exp_flags = 4'b0000;
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, ".out"}, {8'h00, alu_out}, e.out[15:0]);
      chk({e.tag, ".c"}, {15'h0, carry_out}, e.c[15:0]);
      chk({e.tag, ".v"}, {15'h0, overflow}, e.v[15:0]);
      chk({e.tag, ".z"}, {15'h0, zero}, e.z[15:0]);
      chk({e.tag, ".n"}, {15'h0, sign}, e.n[15:0]);
      if (flags_known != 0) begin
        chk({e.tag, ".flags_q"}, {12'h0, flags_q}, {12'h0, exp_flags});
      end
      if (e.rst != 0) begin
        exp_flags = 4'b0000;
        flags_known = 1;
      end else if (e.we != 0) begin
        exp_flags = {e.n[0], e.v[0], e.z[0], e.c[0]};
      end
    end
  end

  initial begin
    int m;
    int a;
    int b;
    int dec;
    int waited;
    // Reset with capture requested: reset must win.
    drive("rst0", 0, 8'hFF, 8'h01, 0, 0, 1, 1);
    drive("rst1", 7, 8'h3C, 8'h00, 1, 0, 0, 1);
    // Directed cases.
    drive("add50", 0, 8'h50, 8'h50, 0, 0, 0, 0);
    drive("addFF", 0, 8'hFF, 8'h01, 0, 0, 1, 0);
    drive("hold", 1, 8'hF0, 8'h0F, 1, 0, 0, 0);
    drive("hold2", 2, 8'hF0, 8'h0F, 0, 0, 0, 0);
    drive("sub50", 5, 8'h50, 8'hB0, 1, 0, 1, 0);
    drive("sub05", 5, 8'h05, 8'h05, 1, 0, 0, 0);
    drive("sr81", 4, 8'h81, 8'h00, 0, 0, 1, 0);
    drive("ror81", 4, 8'h81, 8'h00, 1, 0, 1, 0);
    drive("and", 1, 8'hF0, 8'h0F, 1, 0, 1, 0);
    drive("or", 2, 8'hF0, 8'h0F, 0, 0, 0, 0);
    drive("eor", 3, 8'hAA, 8'hFF, 0, 0, 0, 0);
    drive("pass7", 7, 8'h3C, 8'h99, 1, 0, 1, 0);
    drive("rstwe", 0, 8'h80, 8'h80, 0, 0, 1, 1);
    drive("dec09", 0, 8'h09, 8'h01, 0, 1, 1, 0);
    drive("dec99", 0, 8'h99, 8'h01, 0, 1, 0, 0);
    drive("dsub10", 5, 8'h10, 8'h01, 1, 1, 1, 0);
    drive("pass31", 31, 8'hA5, 8'h5A, 0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 31) : $urandom_range(0, 5);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      dec = $urandom_range(0, 1);
`ifdef ALU_DECIMAL_EN
      if (dec != 0 && (m == 0 || m == 5)) begin
        a = $urandom_range(0, 9) * 16 + $urandom_range(0, 9);
        b = $urandom_range(0, 9) * 16 + $urandom_range(0, 9);
      end
`endif
      drive($sformatf("rnd%0d", i), m, a, b, $urandom_range(0, 1), dec,
            $urandom_range(0, 1), ($urandom_range(0, 15) == 0) ? 1 : 0);
    end
    // Trailing idle cycles so the last capture is observed.
    drive("idle0", 6, 8'h00, 8'h00, 0, 0, 0, 0);
    drive("idle1", 6, 8'h01, 8'h00, 0, 0, 0, 0);
    waited = 0;
    while (sbq.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

8-bit arithmetic/logic unit for the 6502-compatible CPU core. It computes add, subtract, AND, OR, EOR and shift-right/rotate-right on two byte operands. It produces combinational result and N/V/Z/C flags for same-cycle use by the CPU datapath, and keeps a registered copy of the flags. It is instantiated once inside `cpu` and feeds the address registers (ADL/ADH/BAL/IAL), the accumulator and the status register.

## Interface
Parameters: none (mode encodings are fixed constants, see Structure).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset; clears the flag register only.
- alu_a  input  8  operand A; also the shift source.
- alu_b  input  8  operand B.
- mode  input  5  operation select: 0 ADD, 1 AND, 2 OR, 3 EOR, 4 SR, 5 SUB, 6..31 PASS.
- carry_in  input  1  carry/borrow-not in; rotate-in bit for SR.
- decimal  input  1  BCD request for ADD/SUB; ignored unless ALU_DECIMAL_EN is defined.
- flag_we  input  1  capture enable for flags_q.
- alu_out  output  8  result (combinational).
- carry_out  output  1  C flag (combinational).
- overflow  output  1  V flag (combinational).
- zero  output  1  Z flag: alu_out == 8'h00 (combinational).
- sign  output  1  N flag: alu_out[7] (combinational).
- flags_q  output  4  registered {N,V,Z,C}.

## Operation
- ADD: {carry_out, alu_out} = alu_a + alu_b + carry_in, computed at 9-bit width. overflow = (a[7]==b[7]) && (out[7]!=a[7]).
- SUB (6502 SBC): {carry_out, alu_out} = alu_a + ~alu_b + carry_in. carry_out=1 means no borrow. overflow = (a[7]!=b[7]) && (out[7]!=a[7]).
- AND / OR / EOR: bitwise alu_a op alu_b. carry_out = carry_in (pass-through). overflow = 0.
- SR: alu_out = {carry_in, alu_a[7:1]}, so LSR with carry_in=0 and ROR with carry_in=C. carry_out = alu_a[0]. overflow = 0.
- PASS (modes 6..31): alu_out = alu_a, carry_out = carry_in, overflow = 0.
- zero and sign always derive from the final alu_out. The only exception is decimal mode, described under Configuration.
- All wrap-around is modulo 256. 8'hFF+8'h01 gives 8'h00 with C=1.

## Timing
- alu_out, carry_out, overflow, zero and sign are purely combinational, with zero-cycle latency. There are no latches; every output is assigned on every path.
- flags_q: at posedge clk, if reset then flags_q <= 4'b0000. Else if flag_we then flags_q <= {sign, overflow, zero, carry_out}. Else flags_q holds.
- Reset has priority over flag_we in the same cycle.
- Reset does not affect the combinational outputs. During reset they still reflect the current inputs.

## Configuration
- Macro ALU_DECIMAL_EN.
- Defined: when decimal=1 and mode is ADD or SUB, alu_out and carry_out are BCD-adjusted, matching NMOS 6502 behaviour.
  - ADD: add 6 to any nibble greater than 9 and propagate the nibble carry.
  - SUB: subtract 6 per borrowing nibble.
  - Z, N and V come from the unadjusted binary result.
- Not defined: the decimal input is ignored, all arithmetic is binary, and the BCD logic is not synthesised.

## Structure
- Package `alu_pkg` holds:
  - mode constants ALU_ADD=0, ALU_AND=1, ALU_OR=2, ALU_EOR=3, ALU_SR=4, ALU_SUB=5;
  - flag bit indices FLAG_N=3, FLAG_V=2, FLAG_Z=1, FLAG_C=0 for flags_q.
- One sub-module, `alu_bcd_adjust`, generated only under ALU_DECIMAL_EN. It takes the binary sum/difference, the nibble carries and the op, and returns the adjusted byte and carry.

## Test plan
- ADD 8'h50+8'h50, cin=0 -> alu_out 8'hA0, C=0, V=1, N=1, Z=0. ADD 8'hFF+8'h01, cin=0 -> 8'h00, C=1, Z=1, V=0.
- SUB 8'h50-8'hB0, cin=1 -> 8'hA0, C=0, V=1, N=1. SUB 8'h05-8'h05, cin=1 -> 8'h00, C=1, Z=1.
- SR a=8'h81, cin=0 -> 8'h40, C=1, N=0. Same with cin=1 -> 8'hC0, N=1.
- Logic ops:
  - AND 8'hF0&8'h0F -> 8'h00, Z=1, C=cin.
  - OR -> 8'hFF, N=1.
  - EOR 8'hAA^8'hFF -> 8'h55.
  - mode=7, a=8'h3C -> 8'h3C.
- flags_q:
  - flag_we=1 with ADD 8'hFF+1 -> next cycle flags_q=4'b0011.
  - flag_we=0 -> holds.
  - reset asserted together with flag_we=1 -> 4'b0000.
- ALU_DECIMAL_EN, decimal=1:
  - ADD 8'h09+8'h01 -> 8'h10, C=0.
  - ADD 8'h99+8'h01 -> 8'h00, C=1.
  - SUB 8'h10-8'h01, cin=1 -> 8'h09, C=1.
  - Without the macro, the first case gives 8'h0A.
